// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: op codes, register indices,
// instruction field positions, flag/status bit positions and the FSM state type.
package alu_pkg;

   localparam logic [3:0] OP_NOT  = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_ADDC = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_INC  = 4'h6;
   localparam logic [3:0] OP_DEC  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_PASS = 4'hA;
   localparam logic [3:0] OP_ADD  = 4'hB;
   localparam logic [3:0] OP_NOP  = 4'hF;

   localparam logic [1:0] REG_A = 2'd0;
   localparam logic [1:0] REG_B = 2'd1;
   localparam logic [1:0] REG_C = 2'd2;
   localparam logic [1:0] REG_D = 2'd3;

   localparam int unsigned INSTR_W    = 12;
   localparam int unsigned OP_LSB     = 8;
   localparam int unsigned REGSEL_LSB = 4;
   localparam int unsigned DST_LSB    = 2;
   localparam int unsigned WB_BIT     = 1;

   localparam int unsigned FLAG_BORROW = 0;
   localparam int unsigned FLAG_ZERO   = 1;
   localparam int unsigned FLAG_CARRY  = 2;

   localparam int unsigned STAT_BORROW = 0;
   localparam int unsigned STAT_CARRY  = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   // Ops whose result value defines the zero flag.
   function automatic logic op_updates_zero(input logic [3:0] op);
      return op inside {OP_NOT, OP_AND, OP_ADDC, OP_SUB, OP_XOR,
                        OP_INC, OP_DEC, OP_SHL, OP_ADD};
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-word handshake into the ALU issue sequencer.
// valid/ready: a word transfers on a rising edge where in_valid && in_ready; the
// master holds in_instr stable until then, and in_ready never depends on in_valid.
interface alu_issue_ctrl_if;
   import alu_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;

   modport master (output in_valid, output in_instr, input in_ready);
   modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_regfile4.sv
// Four working registers A-D with a direct-load port and a writeback port.
// The sequencer never asserts both ports in the same cycle.
module alu_regfile4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_en,
   input  logic [1:0]       ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             wb_en,
   input  logic [1:0]       wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b,
   output logic [WIDTH-1:0] reg_c,
   output logic [WIDTH-1:0] reg_d
);
   logic [WIDTH-1:0] regs_q [4];
   logic [WIDTH-1:0] regs_d [4];

   always_comb begin
      regs_d = regs_q;
      if (wb_en) begin
         regs_d[wb_addr] = wb_data;
      end else if (ld_en) begin
         regs_d[ld_addr] = ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign reg_a = regs_q[0];
   assign reg_b = regs_q[1];
   assign reg_c = regs_q[2];
   assign reg_d = regs_q[3];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 8-bit ALU: accepts instruction words, drives the
// ALU select/op codes for SETTLE cycles, then writes back the result and flags.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_ctrl_if.slave  in_if,
   input  logic             ld_valid,
   input  logic [1:0]       ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b,
   output logic [WIDTH-1:0] reg_c,
   output logic [WIDTH-1:0] reg_d,
   output logic [3:0]       alu_regsel,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [7:0]       alu_status,
   output logic [2:0]       flags,
   output logic             busy,
   output logic             done,
   output state_e           dbg_state
);
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [3:0]       regsel_q, regsel_d;
   logic [1:0]       dst_q, dst_d;
   logic             wb_q, wb_d;
   logic [2:0]       flags_q, flags_d;
   logic             done_q, done_d;
   logic             ready_c, busy_c, rf_ld_en, rf_wb_en;
   logic             unused_bits;

   assign unused_bits = ^{alu_status[7:3], alu_status[1], in_if.in_instr[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_NOP;
         regsel_q <= '0;
         dst_q    <= REG_A;
         wb_q     <= 1'b0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         regsel_q <= regsel_d;
         dst_q    <= dst_d;
         wb_q     <= wb_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      regsel_d = regsel_q;
      dst_d    = dst_q;
      wb_d     = wb_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      ready_c  = 1'b0;
      busy_c   = 1'b0;
      rf_ld_en = 1'b0;
      rf_wb_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A direct load wins the cycle; the instruction waits one more cycle.
            ready_c = !ld_valid;
            if (ld_valid) begin
               rf_ld_en = 1'b1;
            end else if (in_if.in_valid) begin
               op_d     = in_if.in_instr[OP_LSB +: 4];
               regsel_d = in_if.in_instr[REGSEL_LSB +: 4];
               dst_d    = in_if.in_instr[DST_LSB +: 2];
               wb_d     = in_if.in_instr[WB_BIT];
               cnt_d    = CNT_W'(SETTLE - 1);
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy_c = 1'b1;
            if (cnt_q == '0) begin
               rf_wb_en = wb_q && (op_q <= OP_ADD);
               if (op_updates_zero(op_q)) flags_d[FLAG_ZERO] = (alu_result == '0);
               if (op_q == OP_ADDC || op_q == OP_ADD) flags_d[FLAG_CARRY] = alu_status[STAT_CARRY];
               if (op_q == OP_SUB) flags_d[FLAG_BORROW] = alu_status[STAT_BORROW];
               done_d  = 1'b1;
               op_d    = OP_NOP;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   alu_regfile4 #(.WIDTH(WIDTH)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_en   (rf_ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .wb_en   (rf_wb_en),
      .wb_addr (dst_q),
      .wb_data (alu_result),
      .reg_a   (reg_a),
      .reg_b   (reg_b),
      .reg_c   (reg_c),
      .reg_d   (reg_d)
   );

   assign in_if.in_ready = ready_c;
   assign busy           = busy_c;
   assign done           = done_q;
   assign alu_op         = op_q;
   assign alu_regsel     = regsel_q;
   assign flags          = flags_q;
   assign dbg_state      = state_q;
endmodule
